sccb_config_ov7670: RTL and testbench

- SCCB (I2C-like) write-only master that configures the OV7670 sensor after power-up, before the capture/serial interface is started.
- Walks an external register table (synchronous ROM): one 3-phase write per entry (device ID, register address, data).
- Supports an in-table delay marker, used after the COM7 soft reset.
- Raises `pronto` when the table ends. Top level gates the capture `iniciar` with `pronto`.

---
 rtl/sccb_config_ov7670.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sccb_config_ov7670.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_ov7670.sv
// SCCB write-only master that walks an external register table to configure an OV7670.
// Optional macro SCCB_ACK_CHECK_EN: sample slave ACKs and retry NACKed entries up to MAX_RETRY.
module sccb_config_ov7670 #(
    parameter int unsigned TICK_DIV     = 125,
    parameter logic [7:0]  DEVICE_ID    = 8'h42,
    parameter int unsigned N_MAX        = 256,
    parameter int unsigned DELAY_CYCLES = 500000,
    parameter int unsigned MAX_RETRY    = 3,
    localparam int unsigned IDX_W       = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    output logic [IDX_W-1:0] reg_index,
    input  logic [15:0]      reg_data,
    output logic             sioc,
    output logic             siod_out,
    output logic             siod_oe,
    input  logic             siod_in,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro,
    output logic [3:0]       db_estado
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DLY_W  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [3:0] {
        StOcioso     = 4'h0,
        StLeTabela   = 4'h1,
        StDecodifica = 4'h2,
        StInicio     = 4'h3,
        StBits       = 4'h4,
        StParada     = 4'h5,
        StPausa      = 4'h6,
        StEspera     = 4'h7,
        StFim        = 4'hF
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [26:0]        shreg_q, shreg_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]         quarter_q, quarter_d;
    logic [4:0]         bit_q, bit_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic               iniciar_q;
    logic               pronto_q, pronto_d;

    logic tick;
    logic start_req;
    logic bus_phase;
    logic ack_bit;
    logic entry_done;

`ifdef SCCB_ACK_CHECK_EN
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             nack_q, nack_d;
    logic             erro_q, erro_d;
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
`endif

    assign start_req = iniciar & ~iniciar_q;
    assign bus_phase = (state_q == StInicio) || (state_q == StBits) ||
                       (state_q == StParada) || (state_q == StPausa);
    assign tick      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign ack_bit   = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StOcioso;
            idx_q      <= '0;
            shreg_q    <= '1;
            tick_cnt_q <= '0;
            quarter_q  <= '0;
            bit_q      <= '0;
            delay_q    <= '0;
            iniciar_q  <= 1'b0;
            pronto_q   <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            retry_q    <= '0;
            nack_q     <= 1'b0;
            erro_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tick_cnt_q <= tick_cnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            delay_q    <= delay_d;
            iniciar_q  <= iniciar;
            pronto_q   <= pronto_d;
`ifdef SCCB_ACK_CHECK_EN
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            erro_q     <= erro_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        delay_d    = delay_q;
        pronto_d   = pronto_q;
        entry_done = 1'b0;
        // Quarter timer only runs on the bus, so every phase starts on a fresh quarter.
        tick_cnt_d = (bus_phase && !tick) ? tick_cnt_q + 1'b1 : '0;
`ifdef SCCB_ACK_CHECK_EN
        retry_d    = retry_q;
        nack_d     = nack_q;
        erro_d     = erro_q;
`endif

        unique case (state_q)
            StOcioso, StFim: begin
                if (start_req) begin
                    state_d  = StLeTabela;
                    idx_d    = '0;
                    pronto_d = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                    erro_d   = 1'b0;
                    retry_d  = '0;
`endif
                end
            end
            StLeTabela: state_d = StDecodifica;
            StDecodifica: begin
                shreg_d   = {DEVICE_ID, 1'b1, reg_data[15:8], 1'b1, reg_data[7:0], 1'b1};
                quarter_d = '0;
                bit_d     = '0;
                delay_d   = '0;
`ifdef SCCB_ACK_CHECK_EN
                nack_d    = 1'b0;
`endif
                if (reg_data == 16'hFFFF) begin
                    state_d  = StFim;
                    pronto_d = 1'b1;
                end else if (reg_data == 16'hFFF0) begin
                    state_d = StEspera;
                end else begin
                    state_d = StInicio;
                end
            end
            StInicio: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd1) begin
                        state_d   = StBits;
                        quarter_d = '0;
                    end
                end
            end
            StBits: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
`ifdef SCCB_ACK_CHECK_EN
                    if (quarter_q == 2'd1 && ack_bit && siod_in) begin
                        nack_d = 1'b1;
                    end
`endif
                    if (quarter_q == 2'd3) begin
                        shreg_d = {shreg_q[25:0], 1'b1};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == 5'd26) begin
                            state_d = StParada;
                        end
                    end
                end
            end
            StParada: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd2) begin
                        state_d   = StPausa;
                        quarter_d = '0;
                    end
                end
            end
            StPausa: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    entry_done = (quarter_q == 2'd3);
                end
            end
            StEspera: begin
                delay_d    = delay_q + 1'b1;
                entry_done = (delay_q == DLY_W'(DELAY_CYCLES - 1));
            end
            default: state_d = StOcioso;
        endcase

        if (entry_done) begin
`ifdef SCCB_ACK_CHECK_EN
            if (nack_q) begin
                if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
                    state_d  = StFim;
                    erro_d   = 1'b1;
                    pronto_d = 1'b0;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = StLeTabela;
                end
            end else
`endif
            begin
`ifdef SCCB_ACK_CHECK_EN
                retry_d = '0;
`endif
                // Last table slot finishes the run instead of wrapping to entry 0.
                if (idx_q == IDX_W'(N_MAX - 1)) begin
                    state_d  = StFim;
                    pronto_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StLeTabela;
                end
            end
        end
    end

    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b1;
        unique case (state_q)
            StInicio: siod_out = (quarter_q == 2'd0);
            StBits: begin
                sioc     = (quarter_q == 2'd1) || (quarter_q == 2'd2);
                siod_out = shreg_q[26];
                siod_oe  = !ack_bit;
            end
            StParada: begin
                sioc     = (quarter_q != 2'd0);
                siod_out = (quarter_q == 2'd2);
            end
            default: ;
        endcase
    end

    assign reg_index = idx_q;
    assign ocupado   = (state_q != StOcioso) && (state_q != StFim);
    assign pronto    = pronto_q;
    assign db_estado = state_q;
`ifdef SCCB_ACK_CHECK_EN
    assign erro      = erro_q;
`else
    assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_config_ov7670.sv
// Scoreboard bench: a table-walking reference model queues expected writes, a bus monitor
// decodes SCCB frames and checks them against the queue.
module tb_sccb_config_ov7670;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned N_MAX     = 8;
    localparam int unsigned DELAY     = 100;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned IDX_W     = 3;
    localparam logic [7:0]  DEV       = 8'h42;
`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             iniciar;
    logic [IDX_W-1:0] reg_index;
    logic [15:0]      reg_data;
    logic             sioc, siod_out, siod_oe, siod_in;
    logic             ocupado, pronto, erro;
    logic [3:0]       db_estado;

    sccb_config_ov7670 #(
        .TICK_DIV     (TICK_DIV),
        .DEVICE_ID    (DEV),
        .N_MAX        (N_MAX),
        .DELAY_CYCLES (DELAY),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .iniciar   (iniciar),
        .reg_index (reg_index),
        .reg_data  (reg_data),
        .sioc      (sioc),
        .siod_out  (siod_out),
        .siod_oe   (siod_oe),
        .siod_in   (siod_in),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [N_MAX];
    always @(posedge clk) reg_data <= rom[reg_index];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_q [$];
    int          start_cyc [$];
    int          stop_cyc [$];
    int          frames = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Bus monitor: decodes start/stop conditions and SIOC-rise data bits.
    logic        prev_sioc = 1'b1, prev_line = 1'b1, line, active = 1'b0;
    int          bitcnt = 0;
    logic [26:0] bits, oes;
    logic [23:0] exp_frame;

    always @(negedge clk) begin
        cyc++;
        line = siod_oe ? siod_out : 1'b1;
        if (reset) begin
            active = 1'b0;
        end else if (prev_sioc && sioc && prev_line && !line) begin
            active = 1'b1;
            bitcnt = 0;
            start_cyc.push_back(cyc);
        end else if (prev_sioc && sioc && !prev_line && line) begin
            stop_cyc.push_back(cyc);
            if (active) begin
                frames++;
                check("frame_len", bitcnt, 27);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %h, expected no frame",
                             {bits[26:19], bits[17:10], bits[8:1]});
                end else begin
                    exp_frame = exp_q.pop_front();
                    check("frame_bytes", {bits[26:19], bits[17:10], bits[8:1]}, exp_frame);
                    check("ack_release", oes, 27'b111111110111111110111111110);
                end
            end
            active = 1'b0;
        end else if (!prev_sioc && sioc && active && bitcnt < 27) begin
            bits[26-bitcnt] = line;
            oes[26-bitcnt]  = siod_oe;
            bitcnt++;
        end
        prev_sioc = sioc;
        prev_line = line;
    end

    // Reference: walk the table as the sensor should see it.
    task automatic model_run(output int exp_idx, output bit exp_err);
        exp_err = 1'b0;
        exp_idx = N_MAX - 1;
        for (int i = 0; i < N_MAX; i++) begin
            if (rom[i] == 16'hFFFF) begin
                exp_idx = i;
                break;
            end
            if (rom[i] == 16'hFFF0) continue;
            if (ACK_MODE && siod_in) begin
                for (int k = 0; k < MAX_RETRY; k++) exp_q.push_back({DEV, rom[i]});
                exp_idx = i;
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back({DEV, rom[i]});
        end
    endtask

    task automatic run_table(input int hold, input int repulse, output int busy);
        int exp_idx;
        bit exp_err;
        bit done;
        model_run(exp_idx, exp_err);
        start_cyc.delete();
        stop_cyc.delete();
        busy = 0;
        done = 1'b0;
        @(negedge clk);
        iniciar = 1'b1;
        for (int n = 1; n <= 30000 && !done; n++) begin
            @(negedge clk);
            if (n == hold) iniciar = 1'b0;
            if (repulse != 0 && n == repulse) iniciar = 1'b1;
            if (repulse != 0 && n == repulse + 2) iniciar = 1'b0;
            if (ocupado) busy++;
            if ((pronto || erro) && !ocupado) done = 1'b1;
        end
        iniciar = 1'b0;
        check("run_done", done, 1);
        repeat (2) @(negedge clk);
        check("pronto", pronto, !exp_err);
        check("erro", erro, exp_err);
        check("reg_index", reg_index, exp_idx);
        check("state_fim", db_estado, 4'hF);
        check("frames_left", exp_q.size(), 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < N_MAX; i++) rom[i] = 16'hFFFF;
    endtask

    int  busy;
    int  f0;
    int  n_w;
    bit  seen;
    bit  no_end;

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        siod_in = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sioc", sioc, 1);
        check("rst_siod_out", siod_out, 1);
        check("rst_siod_oe", siod_oe, 1);
        check("rst_reg_index", reg_index, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_erro", erro, 0);
        check("rst_state", db_estado, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single write then end marker: latency 117*TICK_DIV + 2 + 2 marker-read cycles.
        rom[0] = 16'h1280;
        run_table(2, 0, busy);
        check("latency_ok", (busy >= 468 && busy <= 472), 1);

        // Delay marker between two writes.
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1101;
        run_table(2, 0, busy);
        if (start_cyc.size() >= 2 && stop_cyc.size() >= 1) begin
            check("delay_gap_ok", (start_cyc[1] - stop_cyc[0] >= DELAY + 4) &&
                  (start_cyc[1] - stop_cyc[0] <= DELAY + 12 * TICK_DIV), 1);
        end else begin
            check("delay_frames", start_cyc.size(), 2);
        end

        // Reset in the middle of entry 0, then a clean restart.
        clear_rom();
        rom[0] = 16'h1280;
        @(negedge clk);
        iniciar = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            iniciar = 1'b0;
            seen = (db_estado == 4'h4);
        end
        check("reached_bits", seen, 1);
        repeat (30) @(negedge clk);
        f0 = frames;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sioc", sioc, 1);
        check("abort_siod_out", siod_out, 1);
        check("abort_siod_oe", siod_oe, 1);
        check("abort_ocupado", ocupado, 0);
        check("abort_state", db_estado, 0);
        check("abort_reg_index", reg_index, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_no_frame", frames - f0, 0);
        run_table(2, 0, busy);

        // iniciar held high, then re-pulsed while busy: one run only.
        clear_rom();
        rom[0] = 16'h3A04;
        rom[1] = 16'h4010;
        rom[2] = 16'h8C00;
        f0 = frames;
        run_table(1000, 1100, busy);
        check("held_frames", frames - f0, 3);
        repeat (700) @(negedge clk);
        check("held_no_rerun", frames - f0, 3);
        check("held_idle", ocupado, 0);

        // No end marker: every slot written, index parks at N_MAX-1.
        for (int i = 0; i < N_MAX; i++) rom[i] = {8'(i + 1), 8'($urandom)};
        run_table(2, 0, busy);

        // Randomized tables with optional delay markers and end marker.
        for (int r = 0; r < 5; r++) begin
            clear_rom();
            n_w = $urandom_range(1, N_MAX - 1);
            no_end = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N_MAX; i++) begin
                if (i < n_w || no_end) begin
                    if ($urandom_range(0, 4) == 0) rom[i] = 16'hFFF0;
                    else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
                end
            end
            run_table(2, 0, busy);
        end

        // Slave NACKs every byte: retried when ACK checking is built in, ignored otherwise.
        clear_rom();
        rom[0] = 16'h1204;
        siod_in = 1'b1;
        f0 = frames;
        run_table(2, 0, busy);
        check("nack_tx_count", frames - f0, ACK_MODE ? MAX_RETRY : 1);
        siod_in = 1'b0;
        f0 = frames;
        run_table(2, 0, busy);
        check("ack_tx_count", frames - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
